vdu_scanout: RTL and testbench

Display-side reader for the VDU video RAM secondary read port. Generates raster timing (counters, hsync/vsync, data enable) and walks the framebuffer, driving the secondary word address and consuming the returned 32-bit word one cycle later. It serialises each word into RGB565 pixels for the video output stage. The block runs entirely in the pixel clock domain.

---
 rtl/vdu_pkg.sv | 38 +++
 rtl/vdu_scanout_if.sv | 31 +++
 rtl/vdu_timing.sv | 68 ++++++
 rtl/vdu_scanout.sv | 155 +++++++++++++++
 tb/tb_vdu_scanout.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/vdu_pkg.sv
// Shared VDU types and default 640x480@60 raster timing.
// Pure declarations: no latency, no flow control.
package vdu_pkg;

  localparam int CNT_W           = 16;
  localparam int PIXELS_PER_WORD = 2;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Per-pixel control travelling alongside the VRAM read.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
    logic sel;
  } meta_t;

  function automatic rgb565_t pick_half(input logic [31:0] word, input logic hi);
    return hi ? rgb565_t'(word[31:16]) : rgb565_t'(word[15:0]);
  endfunction

endpackage

// File: rtl/vdu_scanout_if.sv
// Scanout bus: VRAM secondary read port plus raster video outputs.
// Plain wires; the scanout side owns every signal except the read data.
interface vdu_scanout_if;
  logic [31:0]          sec_address_o;
  logic [31:0]          sec_data_in_i;
  logic                 hsync_o;
  logic                 vsync_o;
  logic                 de_o;
  vdu_pkg::rgb565_t     pixel_o;
  logic                 frame_start_o;

  modport master (
    output sec_address_o,
    input  sec_data_in_i,
    output hsync_o,
    output vsync_o,
    output de_o,
    output pixel_o,
    output frame_start_o
  );

  modport slave (
    input  sec_address_o,
    output sec_data_in_i,
    input  hsync_o,
    input  vsync_o,
    input  de_o,
    input  pixel_o,
    input  frame_start_o
  );
endinterface

// File: rtl/vdu_timing.sv
// Raster h/v counters with raw (unregistered, asserted-high) region and sync decode.
// Decode is combinational on the counters; free-running, no backpressure.
module vdu_timing
  import vdu_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic reset_i,
  output cnt_t h_o,
  output cnt_t v_o,
  output logic active_o,
  output logic hsync_o,
  output logic vsync_o,
  output logic frame_first_o,
  output logic frame_last_o,
  output logic line_first_o,
  output logic line_last_o
);

  localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam cnt_t H_END   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_END   = cnt_t'(V_TOTAL - 1);

  cnt_t h_q, h_d;
  cnt_t v_q, v_d;
  logic h_wrap;

  always_comb begin
    h_wrap = (h_q == H_END);
    h_d    = h_wrap ? '0 : h_q + cnt_t'(1);
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_END) ? '0 : v_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o           = h_q;
  assign v_o           = v_q;
  assign active_o      = (h_q < cnt_t'(H_ACTIVE)) && (v_q < cnt_t'(V_ACTIVE));
  assign hsync_o       = (h_q >= cnt_t'(H_ACTIVE + H_FP)) &&
                         (h_q <  cnt_t'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_o       = (v_q >= cnt_t'(V_ACTIVE + V_FP)) &&
                         (v_q <  cnt_t'(V_ACTIVE + V_FP + V_SYNC));
  assign frame_first_o = (h_q == '0) && (v_q == '0);
  assign frame_last_o  = h_wrap && (v_q == V_END);
  assign line_first_o  = active_o && (h_q == '0);
  assign line_last_o   = active_o && (h_q == cnt_t'(H_ACTIVE - 1));

endmodule

// File: rtl/vdu_scanout.sv
// Framebuffer scanout: address gen, 3-stage control delay chain, RGB565 pixel mux; outputs lag counters by 3.
// Free-running, no backpressure; `VDU_SCANOUT_PIXEL_DOUBLE_EN selects 2x2 pixel doubling.
module vdu_scanout
  import vdu_pkg::*;
#(
  parameter int          H_ACTIVE  = DEF_H_ACTIVE,
  parameter int          H_FP      = DEF_H_FP,
  parameter int          H_SYNC    = DEF_H_SYNC,
  parameter int          H_BP      = DEF_H_BP,
  parameter int          V_ACTIVE  = DEF_V_ACTIVE,
  parameter int          V_FP      = DEF_V_FP,
  parameter int          V_SYNC    = DEF_V_SYNC,
  parameter int          V_BP      = DEF_V_BP,
  parameter bit          SYNC_POL  = 1'b0,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input logic            clk,
  input logic            reset_i,
  vdu_scanout_if.master  bus
);

  cnt_t h_cnt, v_cnt;
  logic active, hsync_raw, vsync_raw;
  logic frame_first, frame_last, line_first, line_last;

  vdu_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk           (clk),
    .reset_i       (reset_i),
    .h_o           (h_cnt),
    .v_o           (v_cnt),
    .active_o      (active),
    .hsync_o       (hsync_raw),
    .vsync_o       (vsync_raw),
    .frame_first_o (frame_first),
    .frame_last_o  (frame_last),
    .line_first_o  (line_first),
    .line_last_o   (line_last)
  );

  logic fetch;
  logic sel;

`ifdef VDU_SCANOUT_PIXEL_DOUBLE_EN
  assign fetch = active && (h_cnt[1:0] == 2'b00);
  assign sel   = h_cnt[1];
  logic unused_cnt;
  assign unused_cnt = ^{h_cnt[CNT_W-1:2], v_cnt[CNT_W-1:1]};
`else
  assign fetch = active && !h_cnt[0];
  assign sel   = h_cnt[0];
  logic unused_cnt;
  assign unused_cnt = ^{h_cnt[CNT_W-1:1], v_cnt, line_first, line_last};
`endif

  meta_t meta0;
  always_comb begin
    meta0     = '0;
    meta0.de  = active;
    meta0.hs  = hsync_raw;
    meta0.vs  = vsync_raw;
    meta0.fs  = frame_first;
    meta0.sel = sel;
  end

  logic [31:0] addr_q, addr_d;
  logic [31:0] sec_addr_q, sec_addr_d;
  meta_t       meta1_q, meta2_q;
  rgb565_t     pixel_q, pixel_d;
  logic        de_q, hs_q, vs_q, fs_q;

`ifdef VDU_SCANOUT_PIXEL_DOUBLE_EN
  logic [31:0] line_start_q, line_start_d;
`endif

  always_comb begin
    addr_d     = addr_q;
    sec_addr_d = sec_addr_q;
    if (fetch) begin
      sec_addr_d = addr_q;
      addr_d     = addr_q + 32'd1;
    end
`ifdef VDU_SCANOUT_PIXEL_DOUBLE_EN
    // Even display lines rewind so the following odd line re-reads the same words.
    line_start_d = line_start_q;
    if (line_first) begin
      line_start_d = addr_q;
    end
    if (line_last && !v_cnt[0]) begin
      addr_d = line_start_q;
    end
`endif
    if (frame_last) begin
      addr_d = BASE_ADDR;
    end
  end

  // Data for the pixel in stage 2 is on sec_data_in_i now; blanking data is discarded.
  always_comb begin
    pixel_d = '0;
    if (meta2_q.de) begin
      pixel_d = pick_half(bus.sec_data_in_i, meta2_q.sel);
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      addr_q     <= BASE_ADDR;
      sec_addr_q <= BASE_ADDR;
      meta1_q    <= '0;
      meta2_q    <= '0;
      pixel_q    <= '0;
      de_q       <= 1'b0;
      hs_q       <= ~SYNC_POL;
      vs_q       <= ~SYNC_POL;
      fs_q       <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      sec_addr_q <= sec_addr_d;
      meta1_q    <= meta0;
      meta2_q    <= meta1_q;
      pixel_q    <= pixel_d;
      de_q       <= meta2_q.de;
      hs_q       <= meta2_q.hs ? SYNC_POL : ~SYNC_POL;
      vs_q       <= meta2_q.vs ? SYNC_POL : ~SYNC_POL;
      fs_q       <= meta2_q.fs;
    end
  end

`ifdef VDU_SCANOUT_PIXEL_DOUBLE_EN
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      line_start_q <= BASE_ADDR;
    end else begin
      line_start_q <= line_start_d;
    end
  end
`endif

  assign bus.sec_address_o = sec_addr_q;
  assign bus.pixel_o       = pixel_q;
  assign bus.de_o          = de_q;
  assign bus.hsync_o       = hs_q;
  assign bus.vsync_o       = vs_q;
  assign bus.frame_start_o = fs_q;

endmodule

// File: tb/tb_vdu_scanout.sv
// Bench for vdu_scanout on a tiny 8x4 raster: raster-order model plus directed literal checks.
// VRAM model returns word n = {2n+1, 2n}, and all-ones whenever the pixel in stage 2 is blanking.
module tb_vdu_scanout;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam logic [31:0] BASE = 32'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_en = 1'b0;
  int   cyc;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  vdu_scanout_if bus ();

  vdu_scanout #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (1'b0), .BASE_ADDR (BASE)
  ) dut (
    .clk     (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  // Cycles since reset release: counters sit at raster position cyc mod FR.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic bit act(input int k);
    int p = k % FR;
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  function automatic bit fetch_at(input int k);
    int p = k % FR;
`ifdef VDU_SCANOUT_PIXEL_DOUBLE_EN
    return act(k) && ((p % HT) % 4 == 0);
`else
    return act(k) && ((p % HT) % 2 == 0);
`endif
  endfunction

  // Framebuffer pixel index shown at raster position k (also its RGB565 value).
  function automatic int pix(input int k);
    int p = k % FR;
`ifdef VDU_SCANOUT_PIXEL_DOUBLE_EN
    return ((p / HT) / 2) * (HA / 2) + (p % HT) / 2;
`else
    return (p / HT) * HA + (p % HT);
`endif
  endfunction

  function automatic logic [31:0] exp_addr(input int k);
    for (int q = k - 1; q >= 0; q--) begin
      if (fetch_at(q)) return BASE + 32'(pix(q) / 2);
    end
    return BASE;
  endfunction

  logic [15:0] vn;
  logic [31:0] vram_q;
  logic        garbage;
  assign vn      = 16'(bus.sec_address_o - BASE);
  assign garbage = (cyc < 2) || !act(cyc - 2);
  always @(posedge clk) vram_q <= {vn[14:0], 1'b1, vn[14:0], 1'b0};
  assign bus.sec_data_in_i = garbage ? 32'hFFFF_FFFF : vram_q;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (cyc %0d, t=%0t)", nm, got, want, cyc, $time);
  endtask

  // Every-cycle model comparison.
  int   mp, mh, mv;
  bit   m_de, m_fs, m_hs, m_vs;
  int   m_pix;
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst || cyc < 3) begin
        m_de = 1'b0; m_fs = 1'b0; m_hs = 1'b1; m_vs = 1'b1; m_pix = 0;
      end else begin
        mp    = (cyc - 3) % FR;
        mh    = mp % HT;
        mv    = mp / HT;
        m_de  = (mh < HA) && (mv < VA);
        m_pix = m_de ? pix(mp) : 0;
        m_fs  = (mp == 0);
        m_hs  = !((mh >= HA + HF) && (mh < HA + HF + HS));
        m_vs  = !((mv >= VA + VF) && (mv < VA + VF + VS));
      end
      chk("m_de",    {31'h0, bus.de_o},          {31'h0, m_de});
      chk("m_pixel", {16'h0, bus.pixel_o},       32'(m_pix));
      chk("m_fs",    {31'h0, bus.frame_start_o}, {31'h0, m_fs});
      chk("m_hsync", {31'h0, bus.hsync_o},       {31'h0, m_hs});
      chk("m_vsync", {31'h0, bus.vsync_o},       {31'h0, m_vs});
      chk("m_addr",  bus.sec_address_o,          rst ? BASE : exp_addr(cyc));
    end
  end

  task automatic wait_cyc(input int k);
    int guard = 0;
    while (cyc < k && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != k) chk("wait_cyc", 32'(cyc), 32'(k));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", bus.sec_address_o, 32'h100);
    chk("rst_hs",   {31'h0, bus.hsync_o}, 32'h1);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    wait_cyc(1);
    chk("addr_c1", bus.sec_address_o, 32'h100);
    wait_cyc(2);
    chk("fs_c2", {31'h0, bus.frame_start_o}, 32'h0);
    wait_cyc(3);
    chk("fs_c3", {31'h0, bus.frame_start_o}, 32'h1);
    chk("pix_c3", {16'h0, bus.pixel_o}, 32'h0);
`ifdef VDU_SCANOUT_PIXEL_DOUBLE_EN
    chk("addr_c3", bus.sec_address_o, 32'h100);
    wait_cyc(4);
    chk("pix_c4", {16'h0, bus.pixel_o}, 32'h0);
    wait_cyc(5);
    chk("pix_c5", {16'h0, bus.pixel_o}, 32'h1);
    chk("addr_c5", bus.sec_address_o, 32'h101);
`else
    chk("addr_c3", bus.sec_address_o, 32'h101);
    wait_cyc(4);
    chk("pix_c4", {16'h0, bus.pixel_o}, 32'h1);
`endif
    wait_cyc(12);
    chk("hs_h9", {31'h0, bus.hsync_o}, 32'h1);
    wait_cyc(13);
    chk("hs_h10", {31'h0, bus.hsync_o}, 32'h0);
    wait_cyc(14);
    chk("hs_h11", {31'h0, bus.hsync_o}, 32'h0);
    chk("de_h11", {31'h0, bus.de_o}, 32'h0);
    wait_cyc(15);
    chk("hs_h12", {31'h0, bus.hsync_o}, 32'h1);
    wait_cyc(17);
`ifdef VDU_SCANOUT_PIXEL_DOUBLE_EN
    chk("pix_l1", {16'h0, bus.pixel_o}, 32'h0);
`else
    chk("pix_l1", {16'h0, bus.pixel_o}, 32'h8);
`endif
    wait_cyc(27);
    chk("hs_period", {31'h0, bus.hsync_o}, 32'h0);
    wait_cyc(31);
`ifdef VDU_SCANOUT_PIXEL_DOUBLE_EN
    chk("pix_l2", {16'h0, bus.pixel_o}, 32'h4);
`else
    chk("pix_l2", {16'h0, bus.pixel_o}, 32'h10);
`endif
    wait_cyc(72);
    chk("vs_l4", {31'h0, bus.vsync_o}, 32'h1);
    wait_cyc(73);
    chk("vs_l5", {31'h0, bus.vsync_o}, 32'h0);
    wait_cyc(99);
    chk("addr_wrap", bus.sec_address_o, 32'h100);
    wait_cyc(101);
    chk("fs_f2", {31'h0, bus.frame_start_o}, 32'h1);

    // Reset mid-way through line 2 of the second frame, off the clock edge.
    wait_cyc(3 + FR + 2 * HT + 3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_de",   {31'h0, bus.de_o},          32'h0);
    chk("mid_pix",  {16'h0, bus.pixel_o},       32'h0);
    chk("mid_fs",   {31'h0, bus.frame_start_o}, 32'h0);
    chk("mid_hs",   {31'h0, bus.hsync_o},       32'h1);
    chk("mid_vs",   {31'h0, bus.vsync_o},       32'h1);
    chk("mid_addr", bus.sec_address_o,          32'h100);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    wait_cyc(3);
    chk("re_fs", {31'h0, bus.frame_start_o}, 32'h1);
    wait_cyc(4);
`ifdef VDU_SCANOUT_PIXEL_DOUBLE_EN
    chk("re_pix", {16'h0, bus.pixel_o}, 32'h0);
`else
    chk("re_pix", {16'h0, bus.pixel_o}, 32'h1);
`endif
    wait_cyc(2 * FR + 10);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
